// File: rtl/freq_pkg.sv
// Shared constants and state encoding for the frequency gate counter,
// the downstream BCD conversion stage and the display.
package freq_pkg;

   localparam int CNT_W           = 27;
   localparam int MAX_COUNT       = 99_999_999;
   localparam int GATE_CYCLES_DEF = 100_000_000;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [0:0] {
      S_FLUSH = 1'b0,
      S_RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input followed by a rising-edge
// detector; edge_now is decoded from synchronised flops only.
module sig_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic edge_now
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign edge_now = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts rising edges of sig_in over back-to-back windows of GATE_CYCLES clocks and
// publishes the saturated count. Optional macro FREQ_HOLD_EN adds a hold input.
module freq_gate_counter #(
   parameter int GATE_CYCLES = freq_pkg::GATE_CYCLES_DEF,
   parameter int CNT_W       = freq_pkg::CNT_W,
   parameter int MAX_COUNT   = freq_pkg::MAX_COUNT,
   parameter int SYNC_STAGES = freq_pkg::SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq_out,
   output logic             freq_valid,
   output logic             overflow,
   output logic             gate_active
`ifdef FREQ_HOLD_EN
   ,
   input  logic             hold
`endif
);

   import freq_pkg::*;

   localparam int GATE_W  = $clog2(GATE_CYCLES);
   localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

   localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_COUNT);

   state_t             state_reg;
   logic [FLUSH_W-1:0] flush_cnt_reg;
   logic [GATE_W-1:0]  gate_cnt_reg;
   logic [CNT_W-1:0]   edge_cnt_reg;
   logic               sat_reg;
   logic [CNT_W-1:0]   freq_out_reg;
   logic               overflow_reg;
   logic               valid_reg;
   logic               gate_active_reg;

   logic               edge_now;
   logic               hold_eff;
   logic               at_max;
   logic [CNT_W-1:0]   final_cnt;
   logic               final_ovf;

`ifdef FREQ_HOLD_EN
   assign hold_eff = hold;
`else
   assign hold_eff = 1'b0;
`endif

   sig_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_in),
      .edge_now (edge_now)
   );

   // An edge on the last gate cycle still belongs to the window that is closing.
   assign at_max    = (edge_cnt_reg == CNT_MAX);
   assign final_cnt = (edge_now && !at_max) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;
   assign final_ovf = sat_reg | (edge_now & at_max);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_FLUSH;
         flush_cnt_reg   <= '0;
         gate_cnt_reg    <= '0;
         edge_cnt_reg    <= '0;
         sat_reg         <= 1'b0;
         freq_out_reg    <= '0;
         overflow_reg    <= 1'b0;
         valid_reg       <= 1'b0;
         gate_active_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            S_FLUSH: begin
               if (flush_cnt_reg == FLUSH_LAST) begin
                  state_reg       <= S_RUN;
                  gate_active_reg <= 1'b1;
               end else begin
                  flush_cnt_reg <= flush_cnt_reg + 1'b1;
               end
            end
            S_RUN: begin
               if (gate_cnt_reg == GATE_LAST) begin
                  gate_cnt_reg <= '0;
                  edge_cnt_reg <= '0;
                  sat_reg      <= 1'b0;
                  if (!hold_eff) begin
                     freq_out_reg <= final_cnt;
                     overflow_reg <= final_ovf;
                     valid_reg    <= 1'b1;
                  end
               end else begin
                  gate_cnt_reg <= gate_cnt_reg + 1'b1;
                  if (edge_now) begin
                     if (at_max) begin
                        sat_reg <= 1'b1;
                     end else begin
                        edge_cnt_reg <= edge_cnt_reg + 1'b1;
                     end
                  end
               end
            end
            default: state_reg <= S_FLUSH;
         endcase
      end
   end

   assign freq_out    = freq_out_reg;
   assign freq_valid  = valid_reg;
   assign overflow    = overflow_reg;
   assign gate_active = gate_active_reg;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Randomised self-checking bench for freq_gate_counter (GATE_CYCLES=100, MAX_COUNT=20);
// the hold scenario is included when FREQ_HOLD_EN is defined.
module tb_freq_gate_counter;

   localparam int GATE  = 100;
   localparam int MAXC  = 20;
   localparam int SYNC  = 2;
   localparam int CW    = 27;
   localparam int FLUSH = SYNC + 1;
   localparam int NWIN  = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sig_in = 1'b0;
   logic [CW-1:0] freq_out;
   logic          freq_valid;
   logic          overflow;
   logic          gate_active;
`ifdef FREQ_HOLD_EN
   logic          hold = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: cycle index since reset release, per-window edge tallies.
   int t;
   bit s_prev;
   int win_cnt [NWIN];
   bit exp_valid;
   bit exp_ovf;
   bit exp_gate;
   int exp_freq;

   always #5 clk = ~clk;

   freq_gate_counter #(
      .GATE_CYCLES (GATE),
      .CNT_W       (CW),
      .MAX_COUNT   (MAXC),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sig_in      (sig_in),
      .freq_out    (freq_out),
      .freq_valid  (freq_valid),
      .overflow    (overflow),
      .gate_active (gate_active)
`ifdef FREQ_HOLD_EN
      ,
      .hold        (hold)
`endif
   );

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      t = 0;
      s_prev = 1'b0;
      for (int i = 0; i < NWIN; i++) win_cnt[i] = 0;
      exp_valid = 1'b0;
      exp_freq  = 0;
      exp_ovf   = 1'b0;
      exp_gate  = 1'b0;
   endtask

   // Drive one cycle of stimulus, then advance the model to the next cycle.
   // A rise seen by the pin in cycle t reaches the counter in cycle t+2; cycles
   // before FLUSH are not counted, and window w spans cycles FLUSH+GATE*w ..+GATE-1.
   task automatic step(input bit s, input bit h);
      bit h_used;
      int w;
      sig_in = s;
`ifdef FREQ_HOLD_EN
      hold   = h;
      h_used = h;
`else
      h_used = 1'b0;
`endif
      if (t >= 1 && s && !s_prev && (t - 1) / GATE < NWIN)
         win_cnt[(t - 1) / GATE]++;
      s_prev = s;
      @(posedge clk); #1;
      t++;
      exp_gate  = (t >= FLUSH);
      exp_valid = 1'b0;
      if (t >= FLUSH + GATE && (t - FLUSH - GATE) % GATE == 0 && !h_used) begin
         w = (t - FLUSH - GATE) / GATE;
         exp_valid = 1'b1;
         exp_freq  = (win_cnt[w] > MAXC) ? MAXC : win_cnt[w];
         exp_ovf   = (win_cnt[w] > MAXC);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total += 4;
      if (freq_out !== '0) begin bad++; $display("FAIL reset freq_out got=%0d exp=0", freq_out); end
      if (freq_valid !== 1'b0) begin bad++; $display("FAIL reset freq_valid got=%b exp=0", freq_valid); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow got=%b exp=0", overflow); end
      if (gate_active !== 1'b0) begin bad++; $display("FAIL reset gate_active got=%b exp=0", gate_active); end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0);
         total++;
         if (gate_active !== exp_gate) begin
            bad++; $display("FAIL flush gate_active t=%0d got=%b exp=%b", t, gate_active, exp_gate);
         end
      end
   endtask

   task automatic test_period();
      int ph;
      ph = int'($urandom_range(0, 9));
      do_reset();
      for (int i = 0; i < 420; i++) begin
         step(((t + ph) % 10) < 5, 1'b0);
         total += 2;
         if (freq_valid !== exp_valid) begin
            bad++; $display("FAIL period valid t=%0d got=%b exp=%b", t, freq_valid, exp_valid);
         end
         if (freq_out !== CW'(exp_freq) || overflow !== exp_ovf) begin
            bad++; $display("FAIL period result t=%0d got=%0d/%b exp=%0d/%b", t, freq_out, overflow, exp_freq, exp_ovf);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 520; i++) begin
         step((i < 260) ? ((t % 4) < 2) : ((t % 10) < 5), 1'b0);
         total += 2;
         if (freq_valid !== exp_valid) begin
            bad++; $display("FAIL saturation valid t=%0d got=%b exp=%b", t, freq_valid, exp_valid);
         end
         if (freq_out !== CW'(exp_freq) || overflow !== exp_ovf) begin
            bad++; $display("FAIL saturation result t=%0d got=%0d/%b exp=%0d/%b", t, freq_out, overflow, exp_freq, exp_ovf);
         end
      end
   endtask

   // Rises placed so their edges land on the last and first gate cycles of windows.
   task automatic test_boundary();
      bit s;
      do_reset();
      for (int i = 0; i < 520; i++) begin
         s = (t == 100 || t == 102 || t == 200 || t == 202 || t == 301 || t == 400);
         step(s, 1'b0);
         total += 2;
         if (freq_valid !== exp_valid) begin
            bad++; $display("FAIL boundary valid t=%0d got=%b exp=%b", t, freq_valid, exp_valid);
         end
         if (freq_out !== CW'(exp_freq) || overflow !== exp_ovf) begin
            bad++; $display("FAIL boundary result t=%0d got=%0d/%b exp=%0d/%b", t, freq_out, overflow, exp_freq, exp_ovf);
         end
      end
   endtask

   task automatic test_mid_reset();
      int first_v;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (t >= 150 && (t - FLUSH) % GATE == 50) break;
         step((t % 7) < 3, 1'b0);
      end
      do_reset();
      total += 4;
      if (freq_out !== '0) begin bad++; $display("FAIL midreset freq_out got=%0d exp=0", freq_out); end
      if (freq_valid !== 1'b0) begin bad++; $display("FAIL midreset freq_valid got=%b exp=0", freq_valid); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL midreset overflow got=%b exp=0", overflow); end
      if (gate_active !== 1'b0) begin bad++; $display("FAIL midreset gate_active got=%b exp=0", gate_active); end
      first_v = -1;
      for (int i = 0; i < 250; i++) begin
         step((t % 9) < 4, 1'b0);
         if (freq_valid === 1'b1 && first_v < 0) first_v = t;
         total++;
         if (freq_out !== CW'(exp_freq) || overflow !== exp_ovf || freq_valid !== exp_valid) begin
            bad++; $display("FAIL midreset result t=%0d got=%0d/%b/%b exp=%0d/%b/%b", t, freq_out, overflow, freq_valid, exp_freq, exp_ovf, exp_valid);
         end
      end
      total++;
      if (first_v !== FLUSH + GATE) begin
         bad++; $display("FAIL midreset first_valid got=%0d exp=%0d", first_v, FLUSH + GATE);
      end
   endtask

`ifdef FREQ_HOLD_EN
   task automatic test_hold();
      int p;
      int pulses;
      p = int'($urandom_range(5, 12));
      pulses = 0;
      do_reset();
      for (int i = 0; i < 520; i++) begin
         step((t % p) < (p / 2), (t >= 150 && t < 360));
         if (t > 150 && t <= 360 && freq_valid === 1'b1) pulses++;
         total += 2;
         if (freq_valid !== exp_valid) begin
            bad++; $display("FAIL hold valid t=%0d got=%b exp=%b", t, freq_valid, exp_valid);
         end
         if (freq_out !== CW'(exp_freq) || overflow !== exp_ovf) begin
            bad++; $display("FAIL hold result t=%0d got=%0d/%b exp=%0d/%b", t, freq_out, overflow, exp_freq, exp_ovf);
         end
      end
      total++;
      if (pulses !== 0) begin bad++; $display("FAIL hold pulses got=%0d exp=0", pulses); end
   endtask
`endif

   task automatic test_constant();
      int pulses;
      pulses = 0;
      do_reset();
      for (int i = 0; i < 560; i++) begin
         step(i < 320, 1'b0);
         if (freq_valid === 1'b1) pulses++;
         total += 2;
         if (freq_valid !== exp_valid) begin
            bad++; $display("FAIL constant valid t=%0d got=%b exp=%b", t, freq_valid, exp_valid);
         end
         if (freq_out !== CW'(exp_freq) || overflow !== exp_ovf) begin
            bad++; $display("FAIL constant result t=%0d got=%0d/%b exp=%0d/%b", t, freq_out, overflow, exp_freq, exp_ovf);
         end
      end
      total++;
      if (pulses !== 5) begin bad++; $display("FAIL constant pulses got=%0d exp=5", pulses); end
   endtask

   task automatic test_random();
      int dens;
      do_reset();
      for (int i = 0; i < 820; i++) begin
         if (i % 100 == 0) dens = int'($urandom_range(1, 9));
         step(($urandom % 10) < dens, ($urandom % 4) == 0);
         total += 2;
         if (freq_valid !== exp_valid) begin
            bad++; $display("FAIL random valid t=%0d got=%b exp=%b", t, freq_valid, exp_valid);
         end
         if (freq_out !== CW'(exp_freq) || overflow !== exp_ovf) begin
            bad++; $display("FAIL random result t=%0d got=%0d/%b exp=%0d/%b", t, freq_out, overflow, exp_freq, exp_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_period();
      test_saturation();
      test_boundary();
      test_mid_reset();
`ifdef FREQ_HOLD_EN
      test_hold();
`endif
      test_constant();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
